// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronising LFSR predictor with lock / loss-of-lock and error counting.
// Latency: all outputs registered, valid one clk after the edge that samples a bit_valid cycle.
// Backpressure: none; bit_valid=0 cycles stall all state, bits are accepted whenever bit_valid=1.
module prbs_checker #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
  parameter int               LOCK_COUNT  = 16,
  parameter int               LOSS_WIN    = 32,
  parameter int               LOSS_THRESH = 4,
  parameter int               ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_count
);

  localparam int FW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [FW-1:0]    fill_cnt, fill_cnt_nxt;
  logic [7:0]       match_cnt, match_cnt_nxt;
  logic [7:0]       win_cnt, win_cnt_nxt;
  logic [7:0]       win_err, win_err_nxt;
  logic [ERR_W-1:0] err_count_nxt;
  logic             locked_nxt, err_pulse_nxt, lock_lost_nxt;

  // Prediction always comes from the register value before this bit is absorbed.
  logic       pred;
  logic       mismatch;
  logic       fill_done;
  logic       match_ok;
  logic       match_hit;
  logic [7:0] win_err_inc;
  logic       lose;

  assign pred        = ^(shift & TAPS);
  assign mismatch    = (bit_in != pred);
  assign fill_done   = (fill_cnt == FW'(WIDTH - 1));
  // The all-zero register predicts zero forever, so it must never build confidence.
  assign match_ok    = !mismatch && (shift != '0);
  assign match_hit   = match_ok && (match_cnt == 8'(LOCK_COUNT - 1));
  assign win_err_inc = win_err + {7'd0, mismatch};
  assign lose        = mismatch && (win_err_inc >= 8'(LOSS_THRESH));

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      shift     <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_count <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      fill_cnt  <= fill_cnt_nxt;
      match_cnt <= match_cnt_nxt;
      win_cnt   <= win_cnt_nxt;
      win_err   <= win_err_nxt;
      err_count <= err_count_nxt;
      locked    <= locked_nxt;
      err_pulse <= err_pulse_nxt;
      lock_lost <= lock_lost_nxt;
    end
  end

  // Next-state: fill the register, hunt for a run of good predictions, flywheel until errors pile up.
  always_comb begin
    state_nxt = state;
    if (bit_valid) begin
      case (state)
        FILL:    if (fill_done) state_nxt = SEARCH;
        SEARCH:  if (match_hit) state_nxt = LOCKED;
        LOCKED:  if (lose)      state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Datapath next values: shift register, fill/match/window counters and the error counter.
  always_comb begin
    shift_nxt     = shift;
    fill_cnt_nxt  = fill_cnt;
    match_cnt_nxt = match_cnt;
    win_cnt_nxt   = win_cnt;
    win_err_nxt   = win_err;
    err_count_nxt = err_count;
    if (bit_valid) begin
      case (state)
        FILL: begin
          shift_nxt    = {shift[WIDTH-2:0], bit_in};
          fill_cnt_nxt = fill_cnt + FW'(1);
          if (fill_done) match_cnt_nxt = '0;
        end
        SEARCH: begin
          shift_nxt     = {shift[WIDTH-2:0], bit_in};
          match_cnt_nxt = match_ok ? match_cnt + 8'd1 : 8'd0;
          if (match_hit) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end
        end
        LOCKED: begin
          // Flywheel on our own prediction so one bad bit cannot corrupt later predictions.
          shift_nxt = {shift[WIDTH-2:0], pred};
          if (mismatch && (err_count != '1)) err_count_nxt = err_count + ERR_W'(1);
          if (lose) begin
            fill_cnt_nxt = '0;
          end else if (win_cnt == 8'(LOSS_WIN - 1)) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt + 8'd1;
            win_err_nxt = win_err_inc;
          end
        end
        default: ;
      endcase
    end
    if (clear_cnt) err_count_nxt = '0;
  end

  // Output logic: values that appear on the outputs one clock later.
  always_comb begin
    locked_nxt    = (state_nxt == LOCKED);
    err_pulse_nxt = bit_valid && (state == LOCKED) && mismatch;
    lock_lost_nxt = (state == LOCKED) && (state_nxt == FILL);
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a default instance and an ERR_W=4 instance share stimulus,
// both compared every cycle against a bit-history reference model, plus directed checks.
module tb_prbs_checker;

  localparam logic [7:0] TAPS = 8'hB8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_count;
  logic        locked4, err_pulse4, lock_lost4;
  logic [3:0]  err_count4;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost), .err_count(err_count)
  );

  prbs_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .clear_cnt(clear_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .lock_lost(lock_lost4), .err_count(err_count4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Transmit-side generator: each new bit is the XOR of the tapped history bits.
  logic [7:0] gen_s;
  task automatic next_bit(output logic b);
    b = ^(gen_s & TAPS);
    gen_s = {gen_s[6:0], b};
  endtask

  // Reference model: hist[0] is the most recent bit held by the receiver.
  int mode;   // 0 filling, 1 searching, 2 locked
  bit hist[8];
  int m_fill, m_match, m_wc, m_we, m_cnt16, m_cnt4;
  bit m_lk, m_ep, m_ll;

  function automatic bit m_pred();
    bit p = 1'b0;
    for (int k = 0; k < 8; k++) if (TAPS[k]) p ^= hist[k];
    return p;
  endfunction

  function automatic bit m_nonzero();
    for (int k = 0; k < 8; k++) if (hist[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_push(input bit b);
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = b;
  endfunction

  function automatic void m_reset();
    mode = 0; m_fill = 0; m_match = 0; m_wc = 0; m_we = 0; m_cnt16 = 0; m_cnt4 = 0;
    m_lk = 0; m_ep = 0; m_ll = 0;
    for (int k = 0; k < 8; k++) hist[k] = 1'b0;
  endfunction

  function automatic void m_update(input bit v, input bit b, input bit c);
    bit p;
    m_ep = 0;
    m_ll = 0;
    if (v) begin
      if (mode == 0) begin
        m_push(b);
        m_fill++;
        if (m_fill == 8) begin mode = 1; m_match = 0; end
      end else if (mode == 1) begin
        p = m_pred();
        if (b == p && m_nonzero()) m_match++;
        else m_match = 0;
        m_push(b);
        if (m_match == 16) begin mode = 2; m_wc = 0; m_we = 0; end
      end else begin
        p = m_pred();
        m_push(p);
        m_wc++;
        if (b != p) begin
          m_ep = 1;
          m_we++;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        if (b != p && m_we >= 4) begin
          mode = 0; m_fill = 0; m_ll = 1;
        end else if (m_wc == 32) begin
          m_wc = 0; m_we = 0;
        end
      end
    end
    if (c) begin m_cnt16 = 0; m_cnt4 = 0; end
    m_lk = (mode == 2);
  endfunction

  task automatic compare_all();
    check("locked", 32'(locked), 32'(m_lk));
    check("err_pulse", 32'(err_pulse), 32'(m_ep));
    check("lock_lost", 32'(lock_lost), 32'(m_ll));
    check("err_count", 32'(err_count), m_cnt16);
    check("locked_w4", 32'(locked4), 32'(m_lk));
    check("err_pulse_w4", 32'(err_pulse4), 32'(m_ep));
    check("lock_lost_w4", 32'(lock_lost4), 32'(m_ll));
    check("err_count_w4", 32'(err_count4), m_cnt4);
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    bit_valid = v; bit_in = b; clear_cnt = c;
    @(posedge clk);
    m_update(v, b, c);
    #1;
    compare_all();
  endtask

  task automatic send(input bit inv, input bit clr);
    logic b;
    next_bit(b);
    step(1'b1, b ^ inv, clr);
  endtask

  task automatic stall();
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Asynchronous reset entered between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_locked", 32'(locked), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_lock_lost", 32'(lock_lost), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_err_count_w4", 32'(err_count4), 0);
    bit_valid = 1'b0; clear_cnt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gen_s = 8'h01;
  endtask

  // Advance clean bits until the loss window has just restarted.
  task automatic align_window();
    for (int i = 0; i < 64 && mode == 2 && m_wc != 0; i++) send(1'b0, 1'b0);
    check("align_window", m_wc, 0);
  endtask

  task automatic acquire(input string tag);
    for (int i = 1; i <= 24; i++) begin
      send(1'b0, 1'b0);
      if (i == 23) check({tag, "_not_yet"}, 32'(locked), 0);
      if (i == 24) check({tag, "_locked"}, 32'(locked), 1);
    end
  endtask

  initial begin
    int seen;
    m_reset();
    gen_s = 8'h01;
    #2;

    // T1 lock acquisition from seed 01
    do_reset();
    acquire("t1");
    check("t1_err_count", 32'(err_count), 0);

    // T2 single inverted bit
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("t2_err_pulse", 32'(err_pulse), 1);
    send(1'b0, 1'b0);
    check("t2_pulse_once", 32'(err_pulse), 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin send(1'b0, 1'b0); seen += int'(err_pulse); end
    check("t2_no_multiply", seen, 0);
    check("t2_err_count", 32'(err_count), 1);
    check("t2_locked", 32'(locked), 1);

    // T3 four errors in one window drop lock; clean stream relocks after 24 bits
    send(1'b0, 1'b1);
    check("t3_cleared", 32'(err_count), 0);
    align_window();
    for (int e = 0; e < 4; e++) begin
      send(1'b1, 1'b0);
      if (e < 3) begin
        check("t3_still_locked", 32'(locked), 1);
        send(1'b0, 1'b0);
      end
    end
    check("t3_lock_lost", 32'(lock_lost), 1);
    check("t3_unlocked", 32'(locked), 0);
    check("t3_last_pulse", 32'(err_pulse), 1);
    check("t3_err_count", 32'(err_count), 4);
    acquire("t3_relock");

    // T4 gapped valid with garbage on stalled cycles
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) stall();
      else send(1'b0, 1'b0);
      seen += int'(err_pulse) + int'(!locked);
    end
    check("t4_clean_and_locked", seen, 0);

    // T5 all-zero input never locks
    do_reset();
    seen = 0;
    for (int i = 0; i < 100; i++) begin step(1'b1, 1'b0, 1'b0); seen += int'(locked); end
    check("t5_never_locked", seen, 0);
    check("t5_err_count", 32'(err_count), 0);

    // T6 saturation of the narrow counter, clear versus error, mid-stream reset
    do_reset();
    acquire("t6");
    for (int w = 0; w < 20; w++) begin
      align_window();
      send(1'b1, 1'b0);
    end
    check("t6_sat_w4", 32'(err_count4), 15);
    check("t6_err16", 32'(err_count), 20);
    check("t6_locked", 32'(locked4), 1);
    send(1'b1, 1'b1);
    check("t6_clr_pulse", 32'(err_pulse4), 1);
    check("t6_clr_w4", 32'(err_count4), 0);
    check("t6_clr_16", 32'(err_count), 0);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    do_reset();

    // Random traffic: stalls, sparse errors, occasional clears
    acquire("rnd");
    for (int i = 0; i < 3000; i++) begin
      bit clr;
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), clr);
      else send(($urandom_range(0, 23) == 0), clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
